fazyrv_ram_sched: RTL

//  Scheduler/arbiter in front of a dual-read/single-write RAM (registered reads, 1-cycle latency).
//  The RAM performs either a write or a dual read per cycle, never both.

---
 rtl/fazyrv_ram_sched.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fazyrv_ram_sched.sv
// rtl/fazyrv_ram_sched.sv - RAM scheduler/arbiter with zero-fill for a dual-read/single-write RAM
//
// Purpose: shares one registered-read RAM between client 0 (register file,
// dual read + write) and client 1 (debug/loader, single port). Zero-fills the
// RAM after reset or on clr_i. One RAM operation per cycle, either a write or
// a dual read.
//
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   clr_i, clr_busy_o            restart zero-fill / fill in progress
//   c0_w*                        client 0 write request, address, data, grant
//   c0_r*                        client 0 dual read request, addresses, grant,
//                                valid, data
//   c1_*                         client 1 single-port request, grant, valid, data
//   ram_*                        RAM write/read ports

module fazyrv_ram_sched #(
   parameter int REGW    = 32,
   parameter int ADRW    = 5,
   parameter int DEPTH   = 32,
   parameter int MAXWAIT = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            clr_i,
   output logic            clr_busy_o,
   input  logic            c0_wreq_i,
   input  logic [ADRW-1:0] c0_waddr_i,
   input  logic [REGW-1:0] c0_wdata_i,
   output logic            c0_wgnt_o,
   input  logic            c0_rreq_i,
   input  logic [ADRW-1:0] c0_raddr_a_i,
   input  logic [ADRW-1:0] c0_raddr_b_i,
   output logic            c0_rgnt_o,
   output logic            c0_rvalid_o,
   output logic [REGW-1:0] c0_rdata_a_o,
   output logic [REGW-1:0] c0_rdata_b_o,
   input  logic            c1_req_i,
   input  logic            c1_we_i,
   input  logic [ADRW-1:0] c1_addr_i,
   input  logic [REGW-1:0] c1_wdata_i,
   output logic            c1_gnt_o,
   output logic            c1_rvalid_o,
   output logic [REGW-1:0] c1_rdata_o,
   output logic            ram_we_o,
   output logic [ADRW-1:0] ram_waddr_o,
   output logic [REGW-1:0] ram_wdata_o,
   output logic [ADRW-1:0] ram_raddr_a_o,
   output logic [ADRW-1:0] ram_raddr_b_o,
   input  logic [REGW-1:0] ram_rdata_a_i,
   input  logic [REGW-1:0] ram_rdata_b_i
);

   localparam int WCW = $clog2(MAXWAIT + 1);

   typedef enum logic {S_CLEAR, S_IDLE} state_t;

   state_t          state_q, state_d;
   logic [ADRW-1:0] clr_ptr_q, clr_ptr_d;
   logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
   logic [ADRW-1:0] raddr_a_q, raddr_a_d;
   logic [ADRW-1:0] raddr_b_q, raddr_b_d;
   logic            rd_pend_q, rd_pend_d;
   logic            owner_q, owner_d;   // 0: client 0 read, 1: client 1 read
   logic            g_c0w, g_c0r, g_c1, starve;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_CLEAR;
         clr_ptr_q  <= '0;
         wait_cnt_q <= '0;
         raddr_a_q  <= '0;
         raddr_b_q  <= '0;
         rd_pend_q  <= 1'b0;
         owner_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_ptr_q  <= clr_ptr_d;
         wait_cnt_q <= wait_cnt_d;
         raddr_a_q  <= raddr_a_d;
         raddr_b_q  <= raddr_b_d;
         rd_pend_q  <= rd_pend_d;
         owner_q    <= owner_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      clr_ptr_d   = clr_ptr_q;
      wait_cnt_d  = wait_cnt_q;
      raddr_a_d   = raddr_a_q;
      raddr_b_d   = raddr_b_q;
      owner_d     = owner_q;
      rd_pend_d   = 1'b0;
      g_c0w       = 1'b0;
      g_c0r       = 1'b0;
      g_c1        = 1'b0;
      starve      = 1'b0;
      ram_we_o    = 1'b0;
      ram_waddr_o = c0_waddr_i;
      ram_wdata_o = c0_wdata_i;
      case (state_q)
         S_CLEAR: begin
            ram_we_o    = 1'b1;
            ram_waddr_o = clr_ptr_q;
            ram_wdata_o = '0;
            wait_cnt_d  = '0;
            if (clr_ptr_q == ADRW'(DEPTH - 1)) begin
               state_d   = S_IDLE;
               clr_ptr_d = '0;
            end else begin
               clr_ptr_d = clr_ptr_q + ADRW'(1);
            end
         end
         S_IDLE: begin
            // A client 1 request refused MAXWAIT times overrides client 0.
            starve = c1_req_i && (wait_cnt_q == WCW'(MAXWAIT));
            if (starve)         g_c1  = 1'b1;
            else if (c0_wreq_i) g_c0w = 1'b1;
            else if (c0_rreq_i) g_c0r = 1'b1;
            else if (c1_req_i)  g_c1  = 1'b1;

            if (g_c0w) ram_we_o = 1'b1;
            if (g_c0r) begin
               raddr_a_d = c0_raddr_a_i;
               raddr_b_d = c0_raddr_b_i;
               rd_pend_d = 1'b1;
               owner_d   = 1'b0;
            end
            if (g_c1) begin
               if (c1_we_i) begin
                  ram_we_o    = 1'b1;
                  ram_waddr_o = c1_addr_i;
                  ram_wdata_o = c1_wdata_i;
               end else begin
                  raddr_a_d = c1_addr_i;
                  rd_pend_d = 1'b1;
                  owner_d   = 1'b1;
               end
            end

            if (!c1_req_i || g_c1)
               wait_cnt_d = '0;
            else if (wait_cnt_q != WCW'(MAXWAIT))
               wait_cnt_d = wait_cnt_q + WCW'(1);

            // Grants of this cycle still complete; the fill starts next cycle.
            if (clr_i) begin
               state_d   = S_CLEAR;
               clr_ptr_d = '0;
            end
         end
         default: state_d = S_CLEAR;
      endcase
   end

   assign clr_busy_o    = (state_q == S_CLEAR);
   assign c0_wgnt_o     = g_c0w;
   assign c0_rgnt_o     = g_c0r;
   assign c1_gnt_o      = g_c1;
   // Read addresses go to the RAM in the grant cycle and hold otherwise.
   assign ram_raddr_a_o = raddr_a_d;
   assign ram_raddr_b_o = raddr_b_d;
   assign c0_rvalid_o   = rd_pend_q && !owner_q;
   assign c1_rvalid_o   = rd_pend_q && owner_q;
   assign c0_rdata_a_o  = ram_rdata_a_i;
   assign c0_rdata_b_o  = ram_rdata_b_i;
   assign c1_rdata_o    = ram_rdata_a_i;

endmodule
